booth_mul_ctrl: RTL



---
 rtl/booth_pkg.sv | 25 ++
 rtl/Booth_multiplier.sv | 40 ++++
 rtl/booth_row_sum.sv | 26 ++
 rtl/booth_mul_ctrl.sv | 105 ++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants, state encoding and row alignment helper for the Booth multiply unit.
// Exports: BITWIDTH, NUM_ROWS, SIGN_CORR, state_t, align_row().
// No ports; imported by booth_mul_ctrl, booth_row_sum and Booth_multiplier.
package booth_pkg;

  localparam int BITWIDTH = 16;
  localparam int NUM_ROWS = 8;

  // Each row carries its sign bit inverted, so every row is biased by +2^16
  // at its own weight. The biases sum to 32'h5555_0000. This constant is
  // the two's complement of that sum, so it cancels the biases.
  localparam logic [31:0] SIGN_CORR = 32'hAAAB_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // zext32(row) << 2*j
  function automatic logic [31:0] align_row(input logic [16:0] row, input logic [2:0] j);
    return {15'd0, row} << {j, 1'b0};
  endfunction

endpackage

// File: rtl/Booth_multiplier.sv
// Radix-4 Booth partial-product generator: 8 rows of 17 bits plus 8 negate (add) bits.
// Purely combinational; row MSB is the inverted sign, add bit completes the negation.
// Ports: x multiplicand, y multiplier, rows[j] row j, adds[j] +1 for row j.
module Booth_multiplier
  import booth_pkg::*;
(
  input  logic [15:0]                x,
  input  logic [15:0]                y,
  output logic [NUM_ROWS-1:0][16:0] rows,
  output logic [NUM_ROWS-1:0]        adds
);

  logic [16:0] ye;
  logic [2:0]  trip;
  logic [16:0] sel;
  logic [16:0] pp;

  assign ye = {y, 1'b0};

  always_comb begin
    rows = '0;
    adds = '0;
    trip = '0;
    sel  = '0;
    pp   = '0;
    for (int j = 0; j < NUM_ROWS; j++) begin
      trip = ye[2*j+2 -: 3];
      case (trip)
        3'b001, 3'b010, 3'b101, 3'b110: sel = {x[15], x};
        3'b011, 3'b100:                 sel = {x, 1'b0};
        default:                        sel = '0;
      endcase
      // A negative digit is produced as ~sel with the +1 carried in adds[j].
      pp      = trip[2] ? ~sel : sel;
      rows[j] = {~pp[16], pp[15:0]};
      adds[j] = trip[2];
    end
  end

endmodule

// File: rtl/booth_row_sum.sv
// Adds R consecutive aligned Booth rows, starting at row 'base', plus their add bits.
// Combinational, zero latency; the result is a 32-bit partial sum taken mod 2^32.
// Ports: rows/adds all rows, base first row index (cnt), sum aligned partial sum.
module booth_row_sum
  import booth_pkg::*;
#(
  parameter int R = 2
) (
  input  logic [NUM_ROWS-1:0][16:0] rows,
  input  logic [NUM_ROWS-1:0]        adds,
  input  logic [2:0]                 base,
  output logic [31:0]                sum
);

  logic [2:0] idx;

  always_comb begin
    sum = '0;
    idx = '0;
    for (int i = 0; i < R; i++) begin
      idx = base + 3'(i);
      sum = sum + align_row(rows[idx], idx) + align_row({16'd0, adds[idx]}, idx);
    end
  end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Multi-cycle signed 16x16 multiply: latches operands and accumulates ROWS_PER_CYCLE Booth rows per cycle.
// Latency: out_valid 8/ROWS_PER_CYCLE cycles after accept (zero bypass: next cycle); flush/rst kill the operation.
// Backpressure: the result is held in DONE until out_ready; a new op is accepted in the same cycle it drains.
// Ports: clk/rst, flush, in_valid/in_ready/in_x/in_y/in_tag, out_valid/out_ready/out_product/out_tag, busy.
module booth_mul_ctrl #(
  parameter int BITWIDTH       = 16,
  parameter int ROWS_PER_CYCLE = 2,
  parameter int TAG_W          = 5,
  parameter int EARLY_ZERO     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_x,
  input  logic [BITWIDTH-1:0] in_y,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_product,
  output logic [TAG_W-1:0]    out_tag,
  output logic                busy
);
  import booth_pkg::*;

  localparam logic [3:0] R4 = 4'(ROWS_PER_CYCLE);

  state_t                     state;
  logic [BITWIDTH-1:0]        x_q;
  logic [BITWIDTH-1:0]        y_q;
  logic [TAG_W-1:0]           tag_q;
  logic [31:0]                acc;
  logic [2:0]                 cnt;
  logic [NUM_ROWS-1:0][16:0] rows;
  logic [NUM_ROWS-1:0]        adds;
  logic [31:0]                part_sum;
  logic                       accept;
  logic                       last_step;
  logic                       zero_op;

  Booth_multiplier u_ppgen (
    .x    (x_q),
    .y    (y_q),
    .rows (rows),
    .adds (adds)
  );

  booth_row_sum #(.R(ROWS_PER_CYCLE)) u_row_sum (
    .rows (rows),
    .adds (adds),
    .base (cnt),
    .sum  (part_sum)
  );

  assign in_ready  = !rst && !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign last_step = (({1'b0, cnt} + R4) == 4'd8);
  assign zero_op   = (EARLY_ZERO != 0) && ((in_x == '0) || (in_y == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      tag_q <= '0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      x_q   <= in_x;
      y_q   <= in_y;
      tag_q <= in_tag;
      cnt   <= '0;
      if (zero_op) begin
        acc   <= '0;
        state <= DONE;
      end else begin
        acc   <= SIGN_CORR;
        state <= ACC;
      end
    end else begin
      case (state)
        ACC: begin
          acc <= acc + part_sum;
          cnt <= cnt + R4[2:0];
          if (last_step) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign out_product = acc;
  assign out_tag     = tag_q;

endmodule
